// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 13;
  localparam int DATA_W_DEF  = 8;
  localparam int MEM_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between CPU and loader requests.
// MEM_PORT_ARB_RR_EN: on a tie the non-owner wins; otherwise the CPU always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req_i,
  input  logic ld_req_i,
  input  logic last_owner_i,
  output logic grant_vld_o,
  output logic grant_owner_o
);

  assign grant_vld_o = cpu_req_i | ld_req_i;

`ifdef MEM_PORT_ARB_RR_EN
  always_comb begin
    grant_owner_o = cpu_req_i ? OWN_CPU : OWN_LD;
    if (cpu_req_i && ld_req_i) begin
      grant_owner_o = ~last_owner_i;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;

  always_comb begin
    grant_owner_o = cpu_req_i ? OWN_CPU : OWN_LD;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between the CPU path and the loader; each access holds mem_en
// for MEM_LAT cycles then pulses the owner's ack. Tie-break set by MEM_PORT_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              owner_q, owner_d;
  logic              grant_vld;
  logic              grant_owner;

  mem_arb_pick u_pick (
    .cpu_req_i    (cpu_req),
    .ld_req_i     (ld_req),
    .last_owner_i (owner_q),
    .grant_vld_o  (grant_vld),
    .grant_owner_o(grant_owner)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    owner_d   = owner_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    ld_ack    = 1'b0;
    busy      = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rdata     = rdata_q;
    owner     = owner_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          owner_d = grant_owner;
          we_d    = (grant_owner == OWN_LD) ? ld_we    : cpu_we;
          addr_d  = (grant_owner == OWN_LD) ? ld_addr  : cpu_addr;
          wdata_d = (grant_owner == OWN_LD) ? ld_wdata : cpu_wdata;
          cnt_d   = CNT_LOAD;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_en = 1'b1;
        mem_we = we_q;
        busy   = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Read data is captured on the last wait cycle and held until the next read.
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        busy    = 1'b1;
        cpu_ack = (owner_q == OWN_CPU);
        ld_ack  = (owner_q == OWN_LD);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      owner_q <= OWN_CPU;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timeline reference model.
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, ld_req, ld_we;
  logic [12:0] cpu_addr, ld_addr;
  logic [7:0]  cpu_wdata, ld_wdata;
  logic        cpu_ack, ld_ack, mem_en, mem_we, busy, owner;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [12:0] mem_addr;

  mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .MEM_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro model and the reference model's own view of memory contents.
  logic [7:0] mem_arr [0:8191];
  logic [7:0] ref_mem [0:8191];
  assign mem_rdata = mem_arr[mem_addr];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit rnd_en = 0, want_rst = 1, rst_prev = 1;
  bit c_pend = 0, l_pend = 0;

  // Reference timeline: grant seen in cycle g_cyc, access g_cyc+1..g_cyc+L, ack g_cyc+L+1.
  int          g_cyc = -100;
  int          next_free = 0;
  bit          g_own, g_we;
  logic [12:0] g_addr;
  logic [7:0]  g_wdata;
  bit          exp_owner = 0;
  logic [7:0]  exp_rdata = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input bit done, input bit inflight, inout bit pend, output logic req,
                       inout logic we, inout logic [12:0] addr, inout logic [7:0] wdata);
    if (done) pend = 0;
    if (!pend && rnd_en && $urandom_range(0, 99) < 35) begin
      pend  = 1;
      we    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, 15));
      wdata = 8'($urandom);
      req   = 1'b1;
    end else if (pend && inflight && rnd_en && $urandom_range(0, 3) == 0) begin
      // Requester lets go of req and scribbles on its fields mid-access.
      req   = 1'b0;
      addr  = 13'($urandom);
      wdata = 8'($urandom);
    end else begin
      req = pend;
    end
  endtask

  task automatic step();
    bit in_acc, is_resp, win;
    @(negedge clk);
    cyc++;
    if (rst_prev) begin
      g_cyc = -100; next_free = cyc; exp_owner = 0; exp_rdata = 8'h00;
      c_pend = 0; l_pend = 0;
      check("rst_addr", 32'(mem_addr), 32'h0);
      check("rst_wdata", 32'(mem_wdata), 32'h0);
    end
    in_acc  = (cyc >= g_cyc + 1) && (cyc <= g_cyc + L);
    is_resp = (cyc == g_cyc + L + 1);
    if (in_acc && mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
    if (cyc == g_cyc + 1 && g_we) ref_mem[g_addr] = g_wdata;
    if (is_resp && !g_we) exp_rdata = ref_mem[g_addr];

    check("mem_en", 32'(mem_en), 32'(in_acc));
    check("mem_we", 32'(mem_we), 32'(in_acc && g_we));
    if (in_acc) begin
      check("mem_addr", 32'(mem_addr), 32'(g_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(g_wdata));
    end
    check("cpu_ack", 32'(cpu_ack), 32'(is_resp && g_own == 1'b0));
    check("ld_ack", 32'(ld_ack), 32'(is_resp && g_own == 1'b1));
    check("busy", 32'(busy), 32'(in_acc || is_resp));
    check("owner", 32'(owner), 32'(exp_owner));
    check("rdata", 32'(rdata), 32'(exp_rdata));

    drive(is_resp && g_own == 1'b0, (in_acc || is_resp) && g_own == 1'b0,
          c_pend, cpu_req, cpu_we, cpu_addr, cpu_wdata);
    drive(is_resp && g_own == 1'b1, (in_acc || is_resp) && g_own == 1'b1,
          l_pend, ld_req, ld_we, ld_addr, ld_wdata);
    rst      = want_rst;
    rst_prev = want_rst;

    if (!want_rst && cyc >= next_free && (cpu_req || ld_req)) begin
`ifdef MEM_PORT_ARB_RR_EN
      win = (cpu_req && ld_req) ? ~exp_owner : ld_req;
`else
      win = cpu_req ? 1'b0 : 1'b1;
`endif
      g_cyc     = cyc;
      g_own     = win;
      g_we      = win ? ld_we : cpu_we;
      g_addr    = win ? ld_addr : cpu_addr;
      g_wdata   = win ? ld_wdata : cpu_wdata;
      exp_owner = win;
      next_free = cyc + L + 2;
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    for (int i = 0; i < 8192; i++) begin
      mem_arr[i] = 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end

    step(); step();
    want_rst = 0;
    for (int i = 0; i < 10; i++) step();

    // CPU read of a known location.
    mem_arr[5] = 8'hA5; ref_mem[5] = 8'hA5;
    c_pend = 1; cpu_we = 0; cpu_addr = 13'h005; cpu_wdata = 8'h00;
    for (int i = 0; i < 6; i++) step();

    // Loader write.
    l_pend = 1; ld_we = 1; ld_addr = 13'h1FF; ld_wdata = 8'h3C;
    for (int i = 0; i < 6; i++) step();

    // Simultaneous requests.
    c_pend = 1; cpu_we = 1; cpu_addr = 13'h010; cpu_wdata = 8'h11;
    l_pend = 1; ld_we = 0; ld_addr = 13'h1FF;
    for (int i = 0; i < 10; i++) step();

    rnd_en = 1;
    for (int i = 0; i < 2000; i++) step();
    rnd_en = 0;
    for (int i = 0; i < 20; i++) step();

    // Reset in the second wait cycle of a loader write.
    l_pend = 1; ld_we = 1; ld_addr = 13'h0AA; ld_wdata = 8'h5A;
    step(); step();
    want_rst = 1;
    step();
    want_rst = 0;
    for (int i = 0; i < 5; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single data/instruction memory between two requesters: the CPU controller path (fetch, operand read, result write) and a program/data loader port.
- Replaces the direct controller-to-memory strobes with a request/acknowledge handshake.
- Stretches every access over a fixed number of memory wait cycles.
- Sits between the multicycle controller/datapath, the loader and the memory macro.

Parameters:
- ADDR_W, 13, memory address width
- DATA_W, 8, memory data width
- MEM_LAT, 2, cycles mem_en is held per access (≥1); read data is sampled on the last of them

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- ld_req  in  1  loader request, level, held until ld_ack
- ld_we  in  1  loader write enable
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_ack  out  1  one-cycle completion pulse to loader
- rdata  out  DATA_W  read data, shared by both requesters, valid while the ack is high and held afterwards
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in ACCESS and RESP
- owner  out  1  current or last grantee (0 = CPU, 1 = loader)

Behaviour:
- Reset (synchronous, takes priority over everything):
  - State goes to IDLE; counter = 0.
  - All outputs go to 0: mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, ld_ack, rdata, busy, owner.
  - An access in progress is aborted: mem_we drops at that edge and no ack is issued.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If no request, stay in IDLE.
  - If any request, pick a winner: CPU has fixed priority (unless the macro below is defined).
  - Latch the winner's we/addr/wdata into internal registers and set owner to the winner.
  - Load counter = MEM_LAT-1 and go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_we/mem_addr/mem_wdata driven from the latched registers. Requester inputs are ignored after latching.
  - If counter ≠ 0, decrement.
  - If counter = 0 and the access is a read, rdata <= mem_rdata; then go to RESP.
  - Writes leave rdata unchanged.
- RESP:
  - mem_en = mem_we = 0.
  - Ack of the owner = 1 for exactly this cycle.
  - Next state is IDLE.
- Latency:
  - Request first seen in IDLE in cycle t → ACCESS in cycles t+1..t+MEM_LAT → ack in cycle t+MEM_LAT+1.
  - Back-to-back accesses: an IDLE cycle always separates RESP from the next ACCESS.
- Handshake:
  - A requester drops req at the edge on which it sees its ack.
  - A req still high in the IDLE cycle after its ack is treated as a new request.
- Simultaneous requests in IDLE: the loser keeps req high and is served after the winner's RESP+IDLE.
  - With fixed priority, continuous CPU requests starve the loader (accepted).
- req dropped during ACCESS: the access still completes and the ack is still pulsed.
- Only one ack can be high at any cycle; never both.

Optional Feature:
- Macro MEM_PORT_ARB_RR_EN.
- Defined: round-robin on a simultaneous request; the requester that is not the current owner wins. A single requester always wins.
- Undefined: fixed priority, CPU always wins.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE=0, ACCESS=1, RESP=2, 2-bit)
  - owner constants OWN_CPU=1'b0, OWN_LD=1'b1
  - default widths
- One natural sub-module: mem_arb_pick, a combinational winner select from cpu_req, ld_req and the last owner. It contains the MEM_PORT_ARB_RR_EN variant.
- Counter and FSM stay in the top module.

Test Plan (MEM_LAT=2 unless stated):
- Reset then idle: rst high 2 cycles → all outputs 0; no req → mem_en stays 0 for 10 cycles.
- CPU read: cpu_req=1, cpu_we=0, cpu_addr=13'h005 in cycle 0, mem_rdata=8'hA5 → mem_en=1 in cycles 1–2 with mem_addr=13'h005; cpu_ack=1 in cycle 3; rdata=8'hA5 from cycle 3; ld_ack stays 0.
- Loader write: ld_req=1, ld_we=1, ld_addr=13'h1FF, ld_wdata=8'h3C → mem_we=1 in cycles 1–2 with mem_wdata=8'h3C; ld_ack in cycle 3; owner=1; rdata unchanged.
- Contention, both req in cycle 0:
  - Fixed priority: CPU acked in cycle 3, loader in ACCESS cycles 5–6, loader acked in cycle 7.
  - With MEM_PORT_ARB_RR_EN and owner=0 beforehand: loader acked first.
- Reset mid-write: rst=1 in cycle 2 of an ACCESS → mem_we=0 from cycle 3; no ack; state IDLE.
- MEM_LAT=1 and MEM_LAT=4 builds: ack arrives at cycle 2 and cycle 5 respectively after req; cpu_addr changed during ACCESS → mem_addr unchanged.
